edge_event_arbiter: RTL and testbench

- Watches CH_NUM asynchronous input lines and detects rising and/or falling edges per channel, selected by a per-channel mode.
- Holds at most one pending event per channel.
- Serializes pending events onto one valid/ready event port, granting channels round-robin.
- Sits between raw board inputs (keys, sensor strobes) and a single downstream consumer, and counts the events it drops.

---
 rtl/edge_event_arbiter.sv | 150 +++++++++++++++
 tb/tb_edge_event_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// Per-channel edge detector with a one-deep pending slot per channel, drained
// round-robin onto a single valid/ready event port; dropped events are counted.
module edge_event_arbiter #(
  parameter int CH_NUM      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  localparam int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [CH_NUM-1:0]     sig_in,
  input  logic [2*CH_NUM-1:0]   edge_mode,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [CH_W-1:0]       evt_ch,
  output logic                  evt_rise,
  output logic [CNT_W-1:0]      ovf_cnt,
  input  logic                  ovf_clr
);

  localparam int DC_W  = $clog2(CH_NUM + 1);
  localparam int SUM_W = ((CNT_W > DC_W) ? CNT_W : DC_W) + 1;

  typedef enum logic {IDLE, SEND} state_t;

  logic [CH_NUM-1:0] sync_q [SYNC_STAGES];
  logic [CH_NUM-1:0] s;
  logic [CH_NUM-1:0] prev;
  logic [CH_NUM-1:0] rise;
  logic [CH_NUM-1:0] fall;
  logic [CH_NUM-1:0] det;
  logic [CH_NUM-1:0] pend;
  logic [CH_NUM-1:0] pend_dir;
  logic [CH_NUM-1:0] gnt;
  logic [CH_NUM-1:0] drop;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   gnt_idx;
  logic [CH_W-1:0]   cand;
  logic              found;
  logic              grant_en;
  logic [DC_W-1:0]   drop_cnt;
  logic [SUM_W-1:0]  ovf_sum;
  logic [CNT_W-1:0]  ovf_next;
  state_t            state_q;
  state_t            state_d;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev <= '0;
    end else begin
      sync_q[0] <= sig_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev <= s;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    rise = s & ~prev;
    fall = ~s & prev;
    det  = '0;
    for (int i = 0; i < CH_NUM; i++)
      det[i] = (rise[i] & edge_mode[2*i]) | (fall[i] & edge_mode[2*i+1]);
  end

  // Search starts just past the last granted channel, so every channel gets a turn.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= CH_NUM; k++) begin
      cand = CH_W'((int'(rr_ptr) + k) % CH_NUM);
      if (!found && pend[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    unique case (state_q)
      IDLE: if (found) begin
        grant_en = 1'b1;
        state_d  = SEND;
      end
      SEND: if (evt_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (grant_en) gnt[gnt_idx] = 1'b1;
  end

  assign drop      = det & pend & ~gnt;
  assign evt_valid = (state_q == SEND);

  // An occupied slot keeps its oldest event; a slot freed by this cycle's grant can refill at once.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pend     <= '0;
      pend_dir <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (det[i] && (!pend[i] || gnt[i])) begin
          pend[i]     <= 1'b1;
          pend_dir[i] <= rise[i];
        end else if (gnt[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      evt_ch   <= '0;
      evt_rise <= 1'b0;
      rr_ptr   <= CH_W'(CH_NUM - 1);
    end else if (grant_en) begin
      evt_ch   <= gnt_idx;
      evt_rise <= pend_dir[gnt_idx];
      rr_ptr   <= gnt_idx;
    end
  end

  // Clear takes effect before this cycle's drops are added.
  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < CH_NUM; i++) drop_cnt = drop_cnt + DC_W'(drop[i]);
    ovf_sum  = (ovf_clr ? '0 : SUM_W'(ovf_cnt)) + SUM_W'(drop_cnt);
    ovf_next = (ovf_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : ovf_sum[CNT_W-1:0];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) ovf_cnt <= '0;
    else         ovf_cnt <= ovf_next;
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: a cycle table for the single-edge path plus
// hand sequences, with a scoreboard queue checked on every accepted event.
module tb_edge_event_arbiter;

  logic       sys_clk;
  logic       sys_rst;
  logic [3:0] sig_in;
  logic [7:0] edge_mode;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic       evt_rise;
  logic [7:0] ovf_cnt;
  logic       ovf_clr;

  typedef struct {
    int   ch;
    logic rise;
  } exp_t;

  typedef struct {
    logic [3:0] sig;
    logic       ready;
    logic       push;
    int         push_ch;
    logic       push_rise;
    logic       exp_valid;
    int         exp_ch;
    logic       exp_rise;
  } vec_t;

  exp_t sb_q [$];
  vec_t vecs [12];

  int n_vec     = 0;
  int n_err     = 0;
  int cyc       = 0;
  int last_xfer = -1;
  bit check_gap = 1'b0;

  edge_event_arbiter #(.CH_NUM(4), .SYNC_STAGES(2), .CNT_W(8)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .sig_in   (sig_in),
    .edge_mode(edge_mode),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_ch   (evt_ch),
    .evt_rise (evt_rise),
    .ovf_cnt  (ovf_cnt),
    .ovf_clr  (ovf_clr)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] sig, input logic [7:0] mode,
                               input logic ready, input logic clr);
    sig_in    = sig;
    edge_mode = mode;
    evt_ready = ready;
    ovf_clr   = clr;
  endtask

  task automatic stepCycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pushExp(input int ch, input logic rise);
    exp_t e;
    e.ch   = ch;
    e.rise = rise;
    sb_q.push_back(e);
  endtask

  task automatic waitValid(input int budget, input string name);
    int k = 0;
    while (!evt_valid && k < budget) begin
      stepCycle();
      k++;
    end
    checkOutput(name, int'(evt_valid), 1);
  endtask

  task automatic doReset();
    sys_rst = 1'b1;
    applyStimulus(4'h0, 8'h55, 1'b0, 1'b0);
    repeat (2) stepCycle();
    sys_rst = 1'b0;
    repeat (2) stepCycle();
  endtask

  // A transfer seen at the falling edge completes on the following rising edge.
  always @(negedge sys_clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (!sys_rst && evt_valid && evt_ready) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_event_ch", int'(evt_ch), -1);
      end else begin
        e = sb_q.pop_front();
        checkOutput("sb_evt_ch", int'(evt_ch), e.ch);
        checkOutput("sb_evt_rise", int'(evt_rise), int'(e.rise));
        if (check_gap && last_xfer >= 0) checkOutput("rr_gap", cyc - last_xfer, 2);
        last_xfer = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 12; i++)
      vecs[i] = '{sig: 4'h0, ready: 1'b1, push: 1'b0, push_ch: 0, push_rise: 1'b0,
                  exp_valid: 1'b0, exp_ch: 0, exp_rise: 1'b0};
    for (int i = 1; i <= 5; i++) vecs[i].sig = 4'h4;
    vecs[1].push      = 1'b1;
    vecs[1].push_ch   = 2;
    vecs[1].push_rise = 1'b1;
    vecs[4].exp_valid = 1'b1;
    vecs[4].exp_ch    = 2;
    vecs[4].exp_rise  = 1'b1;

    // Reset and idle
    sys_rst = 1'b1;
    applyStimulus(4'h0, 8'h00, 1'b0, 1'b0);
    repeat (3) stepCycle();
    checkOutput("rst_valid", int'(evt_valid), 0);
    checkOutput("rst_ch", int'(evt_ch), 0);
    checkOutput("rst_rise", int'(evt_rise), 0);
    checkOutput("rst_ovf", int'(ovf_cnt), 0);
    sys_rst = 1'b0;
    applyStimulus(4'h0, 8'h55, 1'b0, 1'b0);
    repeat (20) begin
      stepCycle();
      checkOutput("idle_valid", int'(evt_valid), 0);
    end

    // Single rising edge on ch2: latency and one-cycle presentation
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].sig, 8'h55, vecs[i].ready, 1'b0);
      if (vecs[i].push) pushExp(vecs[i].push_ch, vecs[i].push_rise);
      stepCycle();
      checkOutput($sformatf("tbl%0d_valid", i), int'(evt_valid), int'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("tbl%0d_ch", i), int'(evt_ch), vecs[i].exp_ch);
        checkOutput($sformatf("tbl%0d_rise", i), int'(evt_rise), int'(vecs[i].exp_rise));
      end
    end
    checkOutput("single_drained", sb_q.size(), 0);

    // Both-edge mode on ch0
    pushExp(0, 1'b1);
    pushExp(0, 1'b0);
    applyStimulus(4'h1, 8'h57, 1'b1, 1'b0);
    repeat (5) stepCycle();
    applyStimulus(4'h0, 8'h57, 1'b1, 1'b0);
    repeat (10) stepCycle();
    checkOutput("both_drained", sb_q.size(), 0);

    // Round robin with backpressure
    doReset();
    for (int c = 0; c < 4; c++) pushExp(c, 1'b1);
    applyStimulus(4'hF, 8'h55, 1'b0, 1'b0);
    waitValid(10, "rr_first_valid");
    checkOutput("rr_first_ch", int'(evt_ch), 0);
    checkOutput("rr_first_rise", int'(evt_rise), 1);
    repeat (4) begin
      stepCycle();
      checkOutput("rr_hold_valid", int'(evt_valid), 1);
      checkOutput("rr_hold_ch", int'(evt_ch), 0);
    end
    last_xfer = -1;
    check_gap = 1'b1;
    applyStimulus(4'hF, 8'h55, 1'b1, 1'b0);
    repeat (12) stepCycle();
    check_gap = 1'b0;
    checkOutput("rr_drained", sb_q.size(), 0);

    // Overflow on ch1 in both-edge mode
    applyStimulus(4'h0, 8'h55, 1'b0, 1'b0);
    repeat (4) stepCycle();
    for (int t = 0; t < 4; t++) begin
      applyStimulus((t % 2 == 0) ? 4'h2 : 4'h0, 8'h5D, 1'b0, 1'b0);
      repeat (4) stepCycle();
    end
    checkOutput("ovf_valid", int'(evt_valid), 1);
    checkOutput("ovf_ch", int'(evt_ch), 1);
    checkOutput("ovf_rise", int'(evt_rise), 1);
    checkOutput("ovf_cnt", int'(ovf_cnt), 2);
    applyStimulus(4'h0, 8'h5D, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(4'h0, 8'h5D, 1'b0, 1'b0);
    checkOutput("ovf_clr", int'(ovf_cnt), 0);
    pushExp(1, 1'b1);
    pushExp(1, 1'b0);
    applyStimulus(4'h0, 8'h5D, 1'b1, 1'b0);
    repeat (6) stepCycle();
    checkOutput("ovf_drained", sb_q.size(), 0);
    checkOutput("ovf_after_drain", int'(ovf_cnt), 0);

    // Reset while an event is presented and two more are pending
    applyStimulus(4'h7, 8'h55, 1'b0, 1'b0);
    waitValid(10, "mid_valid");
    checkOutput("mid_ch", int'(evt_ch), 2);
    stepCycle();
    sys_rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", int'(evt_valid), 0);
    checkOutput("mid_rst_ch", int'(evt_ch), 0);
    checkOutput("mid_rst_rise", int'(evt_rise), 0);
    applyStimulus(4'h0, 8'h55, 1'b1, 1'b0);
    repeat (2) stepCycle();
    sys_rst = 1'b0;
    repeat (20) begin
      stepCycle();
      checkOutput("post_rst_valid", int'(evt_valid), 0);
    end
    checkOutput("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
